// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - shared L1 D-cache port arbiter for LSU loads and committed stores
// Optional perf counters: define LSU_ARB_PERF_EN.
module lsu_mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int ROB_TAG_WIDTH   = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_req_valid,
  output logic                     ld_req_ready,
  input  logic [XLEN-1:0]          ld_req_address,
  input  logic [ROB_TAG_WIDTH-1:0] ld_req_rob_tag,
  input  logic                     kill_mem_req,
  input  logic                     st_req_valid,
  output logic                     st_req_ready,
  input  logic [XLEN-1:0]          st_req_address,
  input  logic [XLEN-1:0]          st_req_data,
  input  logic [ROB_TAG_WIDTH-1:0] st_req_rob_tag,
  input  logic                     flush,
  input  logic [ROB_TAG_WIDTH-1:0] flush_rob_tag,
  input  logic [ROB_TAG_WIDTH-1:0] rob_head,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_type,
  output logic [XLEN-1:0]          mem_req_address,
  output logic [XLEN-1:0]          mem_req_data,
  input  logic                     mem_resp_valid,
  input  logic [XLEN-1:0]          mem_resp_data,
  output logic                     load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
  output logic [XLEN-1:0]          load_data,
  output logic                     store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag,
`ifdef LSU_ARB_PERF_EN
  output logic                     protocol_error,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_kill_count
`else
  output logic                     protocol_error
`endif
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  // Squash when the tag is at least as young as the flush point, ages taken relative to the ROB head.
  function automatic logic is_squashed(input logic [ROB_TAG_WIDTH-1:0] tag,
                                       input logic [ROB_TAG_WIDTH-1:0] fl_tag,
                                       input logic [ROB_TAG_WIDTH-1:0] head);
    logic [ROB_TAG_WIDTH-1:0] age_tag, age_fl;
    age_tag = tag - head;
    age_fl  = fl_tag - head;
    return age_tag >= age_fl;
  endfunction

  logic                     out_valid, out_type, out_drop;
  logic [XLEN-1:0]          out_addr, out_data;
  logic [ROB_TAG_WIDTH-1:0] out_tag;

  logic                     trk_type [MAX_OUTSTANDING];
  logic                     trk_drop [MAX_OUTSTANDING];
  logic [ROB_TAG_WIDTH-1:0] trk_tag  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         trk_count;
  logic [SW-1:0]            starve_cnt;

  logic can_accept, st_grant, ld_grant, load_stage, handoff;
  logic out_squash, push_drop, pop, pop_drop;
  logic [CNT_W-1:0] occupancy;

  assign occupancy  = trk_count + CNT_W'(out_valid);
  assign can_accept = (!out_valid || mem_req_ready) && (occupancy < CNT_W'(MAX_OUTSTANDING));
  // Readies are gated by reset so every output reads 0 while reset is held.
  assign st_grant   = reset && can_accept && st_req_valid && (starve_cnt < SW'(STARVE_LIMIT));
  assign ld_grant   = reset && can_accept && ld_req_valid && !st_grant;
  assign load_stage = st_grant || (ld_grant && !kill_mem_req);
  assign handoff    = out_valid && mem_req_ready;
  assign out_squash = flush && out_valid && !out_type && is_squashed(out_tag, flush_rob_tag, rob_head);
  assign push_drop  = out_drop || out_squash;
  assign pop        = mem_resp_valid && (trk_count != '0);
  assign pop_drop   = trk_drop[rd_ptr] ||
                      (flush && !trk_type[rd_ptr] && is_squashed(trk_tag[rd_ptr], flush_rob_tag, rob_head));

  assign ld_req_ready    = ld_grant;
  assign st_req_ready    = st_grant;
  assign mem_req_valid   = out_valid;
  assign mem_req_type    = out_type;
  assign mem_req_address = out_addr;
  assign mem_req_data    = out_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_type  <= 1'b0;
      out_drop  <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (load_stage) begin
      out_valid <= 1'b1;
      out_type  <= st_grant;
      out_addr  <= st_grant ? st_req_address : ld_req_address;
      out_data  <= st_grant ? st_req_data : '0;
      out_tag   <= st_grant ? st_req_rob_tag : ld_req_rob_tag;
      out_drop  <= !st_grant && flush && is_squashed(ld_req_rob_tag, flush_rob_tag, rob_head);
    end else if (handoff) begin
      out_valid <= 1'b0;
      out_drop  <= 1'b0;
    end else if (out_squash) begin
      out_drop  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trk_count <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        trk_type[i] <= 1'b0;
        trk_drop[i] <= 1'b0;
        trk_tag[i]  <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (!trk_type[i] && is_squashed(trk_tag[i], flush_rob_tag, rob_head)) trk_drop[i] <= 1'b1;
        end
      end
      // The push write follows the flush loop so a fresh entry's drop bit wins.
      if (handoff) begin
        trk_type[wr_ptr] <= out_type;
        trk_tag[wr_ptr]  <= out_tag;
        trk_drop[wr_ptr] <= push_drop;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      trk_count <= trk_count + CNT_W'(handoff) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (ld_grant) begin
      starve_cnt <= '0;
    end else if (ld_req_valid && st_grant && (starve_cnt < SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_succeeded          <= 1'b0;
      load_succeeded_rob_tag  <= '0;
      load_data               <= '0;
      store_succeeded         <= 1'b0;
      store_succeeded_rob_tag <= '0;
      protocol_error          <= 1'b0;
    end else begin
      load_succeeded  <= pop && !trk_type[rd_ptr] && !pop_drop;
      store_succeeded <= pop && trk_type[rd_ptr];
      if (pop && !trk_type[rd_ptr]) begin
        load_succeeded_rob_tag <= trk_tag[rd_ptr];
        load_data              <= mem_resp_data;
      end
      if (pop && trk_type[rd_ptr]) store_succeeded_rob_tag <= trk_tag[rd_ptr];
      if (mem_resp_valid && (trk_count == '0)) protocol_error <= 1'b1;
    end
  end

`ifdef LSU_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_kill_count   <= '0;
    end else begin
      if (out_valid && !mem_req_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ld_grant && kill_mem_req && (perf_kill_count != '1))
        perf_kill_count <= perf_kill_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req_valid, ld_req_ready, kill_mem_req;
  logic [31:0] ld_req_address;
  logic [4:0]  ld_req_rob_tag;
  logic        st_req_valid, st_req_ready;
  logic [31:0] st_req_address, st_req_data;
  logic [4:0]  st_req_rob_tag;
  logic        flush;
  logic [4:0]  flush_rob_tag, rob_head;
  logic        mem_req_valid, mem_req_ready, mem_req_type;
  logic [31:0] mem_req_address, mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        load_succeeded, store_succeeded, protocol_error;
  logic [4:0]  load_succeeded_rob_tag, store_succeeded_rob_tag;
  logic [31:0] load_data;
`ifdef LSU_ARB_PERF_EN
  logic [31:0] perf_stall_cycles, perf_kill_count;
`endif

  always #5 clk = ~clk;

  lsu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_address(ld_req_address), .ld_req_rob_tag(ld_req_rob_tag),
    .kill_mem_req(kill_mem_req),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_address(st_req_address), .st_req_data(st_req_data), .st_req_rob_tag(st_req_rob_tag),
    .flush(flush), .flush_rob_tag(flush_rob_tag), .rob_head(rob_head),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_type(mem_req_type),
    .mem_req_address(mem_req_address), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .load_succeeded(load_succeeded), .load_succeeded_rob_tag(load_succeeded_rob_tag),
    .load_data(load_data),
    .store_succeeded(store_succeeded), .store_succeeded_rob_tag(store_succeeded_rob_tag),
`ifdef LSU_ARB_PERF_EN
    .protocol_error(protocol_error),
    .perf_stall_cycles(perf_stall_cycles), .perf_kill_count(perf_kill_count)
`else
    .protocol_error(protocol_error)
`endif
  );

  typedef struct {
    logic ld_v;
    logic st_v;
    logic kill;
    logic exp_ld;
    logic exp_st;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   pend = 0;
  bit   auto_resp = 0;
  logic last_ld_rdy, last_st_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ld_req_valid = 0; ld_req_address = 0; ld_req_rob_tag = 0; kill_mem_req = 0;
    st_req_valid = 0; st_req_address = 0; st_req_data = 0; st_req_rob_tag = 0;
    flush = 0; flush_rob_tag = 0; rob_head = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
  endtask

  // Called at a falling edge; samples the readies, advances one clock, returns at the next falling edge.
  task automatic tick();
    logic hs, rs;
    if (auto_resp) mem_resp_valid = (pend > 0);
    #1;
    last_ld_rdy = ld_req_ready;
    last_st_rdy = st_req_ready;
    hs = mem_req_valid && mem_req_ready;
    rs = mem_resp_valid;
    @(posedge clk);
    @(negedge clk);
    if (auto_resp) pend = pend + int'(hs) - int'(rs);
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    auto_resp = 0;
    pend = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{ld_v: 0, st_v: 0, kill: 0, exp_ld: 0, exp_st: 0};
    vecs[1] = '{ld_v: 1, st_v: 0, kill: 0, exp_ld: 1, exp_st: 0};
    vecs[2] = '{ld_v: 0, st_v: 1, kill: 0, exp_ld: 0, exp_st: 1};
    vecs[3] = '{ld_v: 1, st_v: 1, kill: 0, exp_ld: 0, exp_st: 1};
    vecs[4] = '{ld_v: 1, st_v: 0, kill: 1, exp_ld: 1, exp_st: 0};

    idle_inputs();
    reset = 0;
    ld_req_valid = 1;
    st_req_valid = 1;
    #1;
    chk("rst_ld_ready", ld_req_ready, 0);
    chk("rst_st_ready", st_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_load_succ", load_succeeded, 0);
    chk("rst_store_succ", store_succeeded, 0);
    chk("rst_perr", protocol_error, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      ld_req_valid = vecs[i].ld_v;
      st_req_valid = vecs[i].st_v;
      kill_mem_req = vecs[i].kill;
      #1;
      chk($sformatf("vec%0d_ld_ready", i), ld_req_ready, vecs[i].exp_ld);
      chk($sformatf("vec%0d_st_ready", i), st_req_ready, vecs[i].exp_st);
      ld_req_valid = 0; st_req_valid = 0; kill_mem_req = 0;
      @(negedge clk);
    end

    // single load
    do_reset();
    ld_req_valid = 1; ld_req_address = 32'h100; ld_req_rob_tag = 3; mem_req_ready = 1;
    tick();
    chk("s1_ld_ready", last_ld_rdy, 1);
    ld_req_valid = 0;
    chk("s1_mem_valid", mem_req_valid, 1);
    chk("s1_mem_type", mem_req_type, 0);
    chk("s1_mem_addr", mem_req_address, 32'h100);
    chk("s1_mem_data", mem_req_data, 0);
    tick();
    chk("s1_stage_empty", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
    tick();
    mem_resp_valid = 0;
    chk("s1_load_succ", load_succeeded, 1);
    chk("s1_load_tag", load_succeeded_rob_tag, 3);
    chk("s1_load_data", load_data, 32'hDEADBEEF);
    chk("s1_store_succ", store_succeeded, 0);
    tick();
    chk("s1_load_succ_low", load_succeeded, 0);

    // starvation: 8 stores, then one load, then stores again
    do_reset();
    auto_resp = 1;
    ld_req_valid = 1; st_req_valid = 1; mem_req_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("s2_c%0d_ld", i), last_ld_rdy, (i == 8));
      chk($sformatf("s2_c%0d_st", i), last_st_rdy, (i != 8));
    end

    // stall with a store held in the output stage
    do_reset();
    auto_resp = 1;
    st_req_valid = 1; st_req_address = 32'h200; st_req_data = 32'h55; st_req_rob_tag = 7;
    tick();
    chk("s3_first_grant", last_st_rdy, 1);
    chk("s3_type", mem_req_type, 1);
    chk("s3_data", mem_req_data, 32'h55);
    ld_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("s3_stall%0d_st", i), last_st_rdy, 0);
      chk($sformatf("s3_stall%0d_ld", i), last_ld_rdy, 0);
      chk($sformatf("s3_stall%0d_addr", i), mem_req_address, 32'h200);
    end
    ld_req_valid = 0;
    st_req_address = 32'h204; st_req_data = 32'h66; st_req_rob_tag = 8; mem_req_ready = 1;
    tick();
    chk("s3_drain_grant", last_st_rdy, 1);
    st_req_valid = 0;
    chk("s3_reload_addr", mem_req_address, 32'h204);
    tick();
    chk("s3_store_succ", store_succeeded, 1);
    chk("s3_store_tag", store_succeeded_rob_tag, 7);

    // tracker full
    do_reset();
    ld_req_valid = 1; ld_req_address = 32'h300; ld_req_rob_tag = 2; mem_req_ready = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("s4_c%0d_ld", i), last_ld_rdy, (i < 4));
    end
    mem_resp_valid = 1; mem_resp_data = 32'h77;
    tick();
    chk("s4_resp_cycle_ld", last_ld_rdy, 0);
    chk("s4_resp_load_succ", load_succeeded, 1);
    mem_resp_valid = 0;
    tick();
    chk("s4_after_resp_ld", last_ld_rdy, 1);

    // flush with wrapped ROB tags
    do_reset();
    rob_head = 30; mem_req_ready = 1;
    ld_req_valid = 1; ld_req_rob_tag = 31; ld_req_address = 32'h400;
    tick();
    ld_req_valid = 0;
    st_req_valid = 1; st_req_rob_tag = 0; st_req_address = 32'h500; st_req_data = 1;
    tick();
    st_req_valid = 0;
    ld_req_valid = 1; ld_req_rob_tag = 1;
    tick();
    ld_req_rob_tag = 4;
    tick();
    ld_req_valid = 0;
    flush = 1; flush_rob_tag = 1;
    tick();
    flush = 0;
    begin
      logic exp_ld [4];
      logic exp_st [4];
      exp_ld[0] = 1; exp_ld[1] = 0; exp_ld[2] = 0; exp_ld[3] = 0;
      exp_st[0] = 0; exp_st[1] = 1; exp_st[2] = 0; exp_st[3] = 0;
      for (int j = 0; j < 4; j++) begin
        mem_resp_valid = 1; mem_resp_data = 32'hA0 + j;
        tick();
        chk($sformatf("s5_r%0d_load", j), load_succeeded, exp_ld[j]);
        chk($sformatf("s5_r%0d_store", j), store_succeeded, exp_st[j]);
        if (j == 0) begin
          chk("s5_load_tag", load_succeeded_rob_tag, 31);
          chk("s5_load_data", load_data, 32'hA0);
        end
        if (j == 1) chk("s5_store_tag", store_succeeded_rob_tag, 0);
      end
      mem_resp_valid = 0;
    end

    // killed load, then a stray response
    do_reset();
    mem_req_ready = 1;
    ld_req_valid = 1; kill_mem_req = 1; ld_req_rob_tag = 9;
    tick();
    chk("s6_kill_ld_ready", last_ld_rdy, 1);
    ld_req_valid = 0; kill_mem_req = 0;
    chk("s6_no_issue", mem_req_valid, 0);
    tick();
    chk("s6_no_issue_late", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_data = 32'h1234;
    tick();
    mem_resp_valid = 0;
    chk("s6_no_load_succ", load_succeeded, 0);
    chk("s6_perr_set", protocol_error, 1);
    tick();
    tick();
    chk("s6_perr_sticky", protocol_error, 1);
    reset = 0;
    #1;
    chk("s6_perr_cleared", protocol_error, 0);
    reset = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
